// File: rtl/memory_sched_pkg.sv
// memory_sched_pkg: scheduler states, direction codes and slot encoding helpers
package memory_sched_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_SCAN   = 2'd0;
    localparam state_t ST_OFFER  = 2'd1;
    localparam state_t ST_BUSY   = 2'd2;
    localparam state_t ST_UPDATE = 2'd3;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    function automatic logic slot_is_read(input logic [2:0] slot);
        return slot[2];
    endfunction

    function automatic logic [1:0] slot_port(input logic [2:0] slot);
        return slot[1:0];
    endfunction

    function automatic logic [2:0] slot_of(input logic dir, input logic [1:0] port);
        return {dir == DIR_READ, port};
    endfunction

endpackage

// File: rtl/burst_len_calc.sv
// burst_len_calc: eligibility and bounded burst length for one candidate slot
module burst_len_calc
    import memory_sched_pkg::*;
#(
    parameter int REGION_BITS   = 21,
    parameter int MAX_BURST     = 32,
    parameter int FIFO_CNT_BITS = 12
) (
    input  logic                     is_read,
    input  logic [FIFO_CNT_BITS-1:0] fifo_words,
    input  logic [REGION_BITS:0]     level,
    input  logic [REGION_BITS-1:0]   ptr,
    output logic                     eligible,
    output logic [5:0]               len
);

    localparam int CW = (FIFO_CNT_BITS > REGION_BITS + 1) ? FIFO_CNT_BITS : REGION_BITS + 1;
    localparam logic [CW-1:0] S = CW'(1) << REGION_BITS;

    logic [CW-1:0] words, room_lvl, room_ptr, a, b, m;

    // room_lvl is data available for reads or free space for writes; both must be non-zero
    always_comb begin
        words    = CW'(fifo_words);
        room_lvl = is_read ? CW'(level) : S - CW'(level);
        room_ptr = S - CW'(ptr);
        a        = (words < CW'(MAX_BURST)) ? words : CW'(MAX_BURST);
        b        = (room_lvl < room_ptr) ? room_lvl : room_ptr;
        m        = (a < b) ? a : b;
        eligible = (words != '0) && (room_lvl != '0);
        len      = 6'(m);
    end

endmodule

// File: rtl/memory_port_scheduler.sv
// memory_port_scheduler: round-robin cellram burst scheduler over 4 write and 4 read FIFOs
module memory_port_scheduler
    import memory_sched_pkg::*;
#(
    parameter int REGION_BITS   = 21,
    parameter int MAX_BURST     = 32,
    parameter int FIFO_CNT_BITS = 12
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [4*FIFO_CNT_BITS-1:0]     wr_avail_words,
    input  logic [4*FIFO_CNT_BITS-1:0]     rd_space_words,
    output logic                           grant_valid,
    input  logic                           grant_ready,
    output logic                           grant_dir,
    output logic [1:0]                     grant_port,
    output logic [5:0]                     grant_len,
    output logic [REGION_BITS+1:0]         grant_addr,
    input  logic                           burst_done,
    output logic [4*(REGION_BITS+1)-1:0]   buffer_levels,
    output logic                           busy
);

    localparam int RW = REGION_BITS + 1;

    state_t                 state;
    logic [2:0]             scan_slot;
    logic [REGION_BITS-1:0] wr_ptr [4];
    logic [REGION_BITS-1:0] rd_ptr [4];
    logic [RW-1:0]          level  [4];

    logic                     cand_read;
    logic [1:0]               cand_port;
    logic [FIFO_CNT_BITS-1:0] cand_words;
    logic [REGION_BITS-1:0]   cand_ptr;
    logic                     cand_ok;
    logic [5:0]               cand_len;

    assign cand_read  = slot_is_read(scan_slot);
    assign cand_port  = slot_port(scan_slot);
    assign cand_words = cand_read ? rd_space_words[cand_port*FIFO_CNT_BITS +: FIFO_CNT_BITS]
                                  : wr_avail_words[cand_port*FIFO_CNT_BITS +: FIFO_CNT_BITS];
    assign cand_ptr   = cand_read ? rd_ptr[cand_port] : wr_ptr[cand_port];

    burst_len_calc #(
        .REGION_BITS  (REGION_BITS),
        .MAX_BURST    (MAX_BURST),
        .FIFO_CNT_BITS(FIFO_CNT_BITS)
    ) u_len (
        .is_read   (cand_read),
        .fifo_words(cand_words),
        .level     (level[cand_port]),
        .ptr       (cand_ptr),
        .eligible  (cand_ok),
        .len       (cand_len)
    );

    assign grant_valid = state == ST_OFFER;
    assign busy        = state != ST_SCAN;

    for (genvar i = 0; i < 4; i++) begin : g_lvl
        assign buffer_levels[i*RW +: RW] = level[i];
    end

    // FSM, latched grant and per-port pointer/level banks; only UPDATE touches the banks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_SCAN;
            scan_slot  <= '0;
            grant_dir  <= DIR_READ;
            grant_port <= '0;
            grant_len  <= '0;
            grant_addr <= '0;
            for (int p = 0; p < 4; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                level[p]  <= '0;
            end
        end else begin
            case (state)
                ST_SCAN: begin
                    if (cand_ok && enable) begin
                        grant_dir  <= cand_read ? DIR_READ : DIR_WRITE;
                        grant_port <= cand_port;
                        grant_len  <= cand_len;
                        grant_addr <= {cand_port, cand_ptr};
                        state      <= ST_OFFER;
                    end else begin
                        scan_slot <= scan_slot + 3'd1;
                    end
                end
                ST_OFFER: state <= grant_ready ? ST_BUSY : ST_OFFER;
                ST_BUSY:  state <= burst_done ? ST_UPDATE : ST_BUSY;
                default: begin
                    if (grant_dir == DIR_WRITE) begin
                        wr_ptr[grant_port] <= wr_ptr[grant_port] + REGION_BITS'(grant_len);
                        level[grant_port]  <= level[grant_port] + RW'(grant_len);
                    end else begin
                        rd_ptr[grant_port] <= rd_ptr[grant_port] + REGION_BITS'(grant_len);
                        level[grant_port]  <= level[grant_port] - RW'(grant_len);
                    end
                    scan_slot <= slot_of(grant_dir, grant_port) + 3'd1;
                    state     <= ST_SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_port_scheduler.sv
// tb_memory_port_scheduler: randomized and directed checks against a transaction-level model
module tb_memory_port_scheduler;

    localparam int RB = 6;
    localparam int MB = 32;
    localparam int FW = 12;
    localparam int S  = 1 << RB;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic grant_ready = 1'b0;
    logic burst_done = 1'b0;
    logic [4*FW-1:0] wr_avail_words, rd_space_words;
    logic grant_valid, grant_dir, busy;
    logic [1:0] grant_port;
    logic [5:0] grant_len;
    logic [RB+1:0] grant_addr;
    logic [4*(RB+1)-1:0] buffer_levels;

    logic [FW-1:0] wa [4];
    logic [FW-1:0] rs [4];

    int m_wp [4];
    int m_rp [4];
    int m_lv [4];
    int m_next;
    bit m_sync;

    int n_cmp = 0;
    int n_bad = 0;
    int cur_slot, cur_len;
    logic g_dir;
    logic [1:0] g_port;
    logic [5:0] g_len;
    logic [RB+1:0] g_addr;

    always #5 clk = ~clk;

    assign wr_avail_words = {wa[3], wa[2], wa[1], wa[0]};
    assign rd_space_words = {rs[3], rs[2], rs[1], rs[0]};

    memory_port_scheduler #(.REGION_BITS(RB), .MAX_BURST(MB), .FIFO_CNT_BITS(FW)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .wr_avail_words(wr_avail_words),
        .rd_space_words(rd_space_words),
        .grant_valid   (grant_valid),
        .grant_ready   (grant_ready),
        .grant_dir     (grant_dir),
        .grant_port    (grant_port),
        .grant_len     (grant_len),
        .grant_addr    (grant_addr),
        .burst_done    (burst_done),
        .buffer_levels (buffer_levels),
        .busy          (busy)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int min2(input int a, input int b);
        return a < b ? a : b;
    endfunction

    // words a slot would move right now, 0 when the slot is not eligible
    function automatic int mlen(input int slot);
        int p = slot % 4;
        if (slot < 4) begin
            if (wa[p] == 0 || m_lv[p] >= S) return 0;
            return min2(min2(MB, int'(wa[p])), min2(S - m_lv[p], S - m_wp[p]));
        end
        if (m_lv[p] == 0 || rs[p] == 0) return 0;
        return min2(min2(MB, int'(rs[p])), min2(m_lv[p], S - m_rp[p]));
    endfunction

    function automatic int predict();
        for (int k = 0; k < 8; k++)
            if (mlen((m_next + k) % 8) > 0) return (m_next + k) % 8;
        return -1;
    endfunction

    function automatic int level_of(input int p);
        return int'(buffer_levels[p*(RB+1) +: RB+1]);
    endfunction

    function automatic logic [FW-1:0] rnd_words();
        return ($urandom_range(0, 3) == 0) ? '0 : FW'($urandom_range(1, 90));
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        grant_ready = 1'b0;
        burst_done = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        for (int p = 0; p < 4; p++) begin
            m_wp[p] = 0;
            m_rp[p] = 0;
            m_lv[p] = 0;
        end
        m_next = 0;
        m_sync = 1'b1;
    endtask

    task automatic do_grant(input string tag, input int hold, input bit drop_en, output bit ok);
        int t = 0;
        int slot;
        logic [FW-1:0] sv [4];
        ok = 1'b0;
        while (!grant_valid && t < 40) begin
            tick();
            t++;
        end
        if (!grant_valid) begin
            chk({tag, "_timeout"}, 0, 1);
            return;
        end
        slot = (grant_dir ? 0 : 4) + int'(grant_port);
        g_dir = grant_dir;
        g_port = grant_port;
        g_len = grant_len;
        g_addr = grant_addr;
        if (m_sync) chk({tag, "_slot"}, slot, predict());
        else chk({tag, "_elig"}, longint'(mlen(slot) > 0), 1);
        chk({tag, "_len"}, longint'(grant_len), mlen(slot));
        chk({tag, "_addr"}, longint'(grant_addr), (slot % 4) * S + (slot < 4 ? m_wp[slot % 4] : m_rp[slot % 4]));
        cur_slot = slot;
        cur_len = mlen(slot);
        if (drop_en) enable = 1'b0;
        sv = wa;
        for (int i = 0; i < hold; i++) begin
            wa[$urandom_range(0, 3)] = FW'($urandom_range(0, 200));
            burst_done = (i % 3 == 1);
            tick();
            chk({tag, "_hold"}, longint'({grant_valid, grant_dir, grant_port, grant_len, grant_addr}),
                longint'({1'b1, g_dir, g_port, g_len, g_addr}));
        end
        burst_done = 1'b0;
        wa = sv;
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        chk({tag, "_vdrop"}, longint'(grant_valid), 0);
        chk({tag, "_busy"}, longint'(busy), 1);
        ok = 1'b1;
    endtask

    task automatic finish_grant(input string tag);
        int p = cur_slot % 4;
        repeat ($urandom_range(0, 3)) tick();
        burst_done = 1'b1;
        tick();
        burst_done = 1'b0;
        chk({tag, "_upd_busy"}, longint'(busy), 1);
        tick();
        if (cur_slot < 4) begin
            m_wp[p] = (m_wp[p] + cur_len) % S;
            m_lv[p] += cur_len;
        end else begin
            m_rp[p] = (m_rp[p] + cur_len) % S;
            m_lv[p] -= cur_len;
        end
        m_next = (cur_slot + 1) % 8;
        m_sync = 1'b1;
        for (int q = 0; q < 4; q++) chk({tag, "_level"}, level_of(q), m_lv[q]);
        chk({tag, "_idle"}, longint'(busy), 0);
    endtask

    task automatic quiet(input string tag, input int cycles);
        int cnt = 0;
        repeat (cycles) begin
            tick();
            cnt += int'(grant_valid);
        end
        chk(tag, cnt, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        for (int p = 0; p < 4; p++) begin
            wa[p] = '0;
            rs[p] = '0;
        end
        enable = 1'b1;

        do_reset();
        chk("rst_valid", longint'(grant_valid), 0);
        chk("rst_fields", longint'({grant_dir, grant_port, grant_len, grant_addr}), 0);
        chk("rst_levels", longint'(buffer_levels), 0);
        chk("rst_busy", longint'(busy), 0);
        quiet("rst_idle", 50);

        wa[1] = 40;
        for (int p = 0; p < 4; p++) rs[p] = 100;
        do_reset();
        do_grant("rr_w1", 0, 1'b0, ok);
        chk("rr_w1_dir", longint'(g_dir), 1);
        chk("rr_w1_port", longint'(g_port), 1);
        chk("rr_w1_len", longint'(g_len), 32);
        chk("rr_w1_addr", longint'(g_addr), 64);
        wa[1] = 8;
        if (ok) finish_grant("rr_w1");
        chk("rr_lvl1_up", level_of(1), 32);
        do_grant("rr_r1", 0, 1'b0, ok);
        chk("rr_r1_dir", longint'(g_dir), 0);
        chk("rr_r1_port", longint'(g_port), 1);
        chk("rr_r1_len", longint'(g_len), 32);
        chk("rr_r1_addr", longint'(g_addr), 64);
        if (ok) finish_grant("rr_r1");
        chk("rr_lvl1_dn", level_of(1), 0);

        for (int p = 0; p < 4; p++) begin
            wa[p] = '0;
            rs[p] = '0;
        end
        wa[0] = 60;
        do_reset();
        do_grant("wrap_w_a", 0, 1'b0, ok);
        wa[0] = 28;
        if (ok) finish_grant("wrap_w_a");
        do_grant("wrap_w_b", 0, 1'b0, ok);
        wa[0] = 0;
        rs[0] = 60;
        if (ok) finish_grant("wrap_w_b");
        chk("wrap_lvl60", level_of(0), 60);
        do_grant("wrap_r_a", 0, 1'b0, ok);
        rs[0] = 28;
        if (ok) finish_grant("wrap_r_a");
        do_grant("wrap_r_b", 0, 1'b0, ok);
        rs[0] = 0;
        wa[0] = 10;
        if (ok) finish_grant("wrap_r_b");
        do_grant("wrap_tail", 0, 1'b0, ok);
        chk("wrap_tail_len", longint'(g_len), 4);
        chk("wrap_tail_addr", longint'(g_addr), 60);
        wa[0] = 6;
        if (ok) finish_grant("wrap_tail");
        do_grant("wrap_head", 0, 1'b0, ok);
        chk("wrap_head_len", longint'(g_len), 6);
        chk("wrap_head_addr", longint'(g_addr), 0);
        if (ok) finish_grant("wrap_head");

        wa[0] = 100;
        rs[0] = 0;
        do_reset();
        do_grant("full_a", 0, 1'b0, ok);
        if (ok) finish_grant("full_a");
        do_grant("full_b", 0, 1'b0, ok);
        if (ok) finish_grant("full_b");
        chk("full_lvl64", level_of(0), 64);
        quiet("full_quiet", 30);

        wa[0] = 0;
        wa[2] = 20;
        do_reset();
        do_grant("hs", 20, 1'b0, ok);
        chk("hs_port", longint'(g_port), 2);
        chk("hs_len", longint'(g_len), 20);
        if (ok) finish_grant("hs");

        wa[2] = 0;
        wa[3] = 10;
        do_reset();
        do_grant("mr_a", 0, 1'b0, ok);
        wa[3] = 5;
        if (ok) finish_grant("mr_a");
        do_grant("mr_b", 0, 1'b0, ok);
        #3;
        reset = 1'b0;
        #1;
        chk("mr_async", longint'({grant_valid, grant_dir, grant_port, grant_len, grant_addr, busy}), 0);
        chk("mr_levels", longint'(buffer_levels), 0);

        for (int p = 0; p < 4; p++) begin
            wa[p] = 20;
            rs[p] = 0;
        end
        do_reset();
        do_grant("en_first", 0, 1'b0, ok);
        for (int p = 0; p < 4; p++) rs[p] = 50;
        if (ok) finish_grant("en_first");
        do_grant("en_pend", 4, 1'b1, ok);
        if (ok) finish_grant("en_pend");
        quiet("en_off_quiet", 30);
        enable = 1'b1;
        m_sync = 1'b0;
        do_grant("en_resume", 0, 1'b0, ok);
        if (ok) finish_grant("en_resume");

        for (int p = 0; p < 4; p++) begin
            wa[p] = rnd_words();
            rs[p] = rnd_words();
        end
        wa[0] = FW'($urandom_range(1, 90));
        do_reset();
        for (int it = 0; it < 150; it++) begin
            do_grant("rnd", 0, 1'b0, ok);
            if (!ok) begin
                wa[0] = 5;
                do_reset();
                continue;
            end
            for (int p = 0; p < 4; p++) begin
                wa[p] = rnd_words();
                rs[p] = rnd_words();
            end
            finish_grant("rnd");
            if (predict() < 0) begin
                int p = $urandom_range(0, 3);
                quiet("rnd_quiet", 12);
                if (m_lv[p] < S) wa[p] = FW'($urandom_range(1, 90));
                else rs[p] = FW'($urandom_range(1, 90));
                m_sync = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
